arm_mc_controller: RTL and testbench

- Multicycle control unit for the ARM datapath. Decodes the instruction register fields and sequences the shared 32-bit ALU over several cycles: PC+4, address generation, data processing and branch target.
- Holds the architectural NZCV flag register and evaluates condition codes.
- Drives every datapath mux select and write enable. Sits between the instruction register and the datapath.

---
 rtl/arm_ctrl_pkg.sv | 81 ++++++++
 rtl/arm_cond_check.sv | 47 ++++
 rtl/arm_mc_controller.sv | 161 ++++++++++++++++
 tb/tb_arm_mc_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_ctrl_pkg
// Brief    : Shared types and encodings for the multicycle ARM control unit:
//            FSM states, ALU control codes, data-processing commands,
//            condition codes, NZCV bit indices and the command decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package arm_ctrl_pkg;

   // Controller states, 4-bit encoding
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTER = 4'd6,
      ST_EXECUTEI = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BRANCH   = 4'd9
   } state_t;

   // ALUControl encodings
   localparam logic [1:0] c_alu_add = 2'b00;
   localparam logic [1:0] c_alu_sub = 2'b01;
   localparam logic [1:0] c_alu_and = 2'b10;
   localparam logic [1:0] c_alu_orr = 2'b11;

   // Data-processing cmd field
   localparam logic [3:0] c_cmd_and = 4'b0000;
   localparam logic [3:0] c_cmd_sub = 4'b0010;
   localparam logic [3:0] c_cmd_add = 4'b0100;
   localparam logic [3:0] c_cmd_cmp = 4'b1010;
   localparam logic [3:0] c_cmd_orr = 4'b1100;

   // Condition field
   localparam logic [3:0] c_cond_eq = 4'b0000;
   localparam logic [3:0] c_cond_ne = 4'b0001;
   localparam logic [3:0] c_cond_cs = 4'b0010;
   localparam logic [3:0] c_cond_cc = 4'b0011;
   localparam logic [3:0] c_cond_mi = 4'b0100;
   localparam logic [3:0] c_cond_pl = 4'b0101;
   localparam logic [3:0] c_cond_vs = 4'b0110;
   localparam logic [3:0] c_cond_vc = 4'b0111;
   localparam logic [3:0] c_cond_hi = 4'b1000;
   localparam logic [3:0] c_cond_ls = 4'b1001;
   localparam logic [3:0] c_cond_ge = 4'b1010;
   localparam logic [3:0] c_cond_lt = 4'b1011;
   localparam logic [3:0] c_cond_gt = 4'b1100;
   localparam logic [3:0] c_cond_le = 4'b1101;
   localparam logic [3:0] c_cond_al = 4'b1110;
   localparam logic [3:0] c_cond_nv = 4'b1111;

   // NZCV bit positions
   localparam int c_flag_n = 3;
   localparam int c_flag_z = 2;
   localparam int c_flag_c = 1;
   localparam int c_flag_v = 0;

   // cmd -> ALUControl; unsupported commands fall back to add
   function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
      case (cmd)
         c_cmd_add: cmd_alu = c_alu_add;
         c_cmd_sub: cmd_alu = c_alu_sub;
         c_cmd_cmp: cmd_alu = c_alu_sub;
         c_cmd_and: cmd_alu = c_alu_and;
         c_cmd_orr: cmd_alu = c_alu_orr;
         default:   cmd_alu = c_alu_add;
      endcase
   endfunction

   // Commands that write a result register (CMP and unsupported ones do not)
   function automatic logic cmd_writes(input logic [3:0] cmd);
      cmd_writes = (cmd == c_cmd_add) || (cmd == c_cmd_sub) ||
                   (cmd == c_cmd_and) || (cmd == c_cmd_orr);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arm_cond_check.sv
`default_nettype none
// ============================================================================
// Module   : arm_cond_check
// Brief    : Combinational ARM condition-code evaluation of Cond against NZCV.
// Revision : 1.0 - initial release
// ============================================================================
module arm_cond_check
   import arm_ctrl_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_condex
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = i_flags[c_flag_n];
   assign w_z = i_flags[c_flag_z];
   assign w_c = i_flags[c_flag_c];
   assign w_v = i_flags[c_flag_v];

   // Condition decode; the never-condition (1111) evaluates false
   always_comb begin
      o_condex = 1'b0;
      case (i_cond)
         c_cond_eq: o_condex = w_z;
         c_cond_ne: o_condex = ~w_z;
         c_cond_cs: o_condex = w_c;
         c_cond_cc: o_condex = ~w_c;
         c_cond_mi: o_condex = w_n;
         c_cond_pl: o_condex = ~w_n;
         c_cond_vs: o_condex = w_v;
         c_cond_vc: o_condex = ~w_v;
         c_cond_hi: o_condex = w_c & ~w_z;
         c_cond_ls: o_condex = ~w_c | w_z;
         c_cond_ge: o_condex = (w_n == w_v);
         c_cond_lt: o_condex = (w_n != w_v);
         c_cond_gt: o_condex = ~w_z & (w_n == w_v);
         c_cond_le: o_condex = w_z | (w_n != w_v);
         c_cond_al: o_condex = 1'b1;
         c_cond_nv: o_condex = 1'b0;
         default:   o_condex = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : arm_mc_controller
// Brief    : Multicycle ARM control unit. Sequences the shared ALU through
//            fetch/decode/execute states, holds NZCV, and drives every
//            datapath select and write enable.
// Revision : 1.0 - initial release
// ============================================================================
module arm_mc_controller
   import arm_ctrl_pkg::*;
#(
   parameter logic [3:0] FLAGS_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUControl
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_flags;
   logic       r_condexl;
   logic       w_condex;
   logic [3:0] w_cmd;
   logic [1:0] w_alu;
   logic       w_dp_wr;
   logic       w_flag_upd;

   assign w_cmd   = Funct[4:1];
   assign w_alu   = cmd_alu(w_cmd);
   assign w_dp_wr = r_condexl & cmd_writes(w_cmd);

   // Flags change only on the edge that ends an executed data-processing step
   assign w_flag_upd = ((r_state == ST_EXECUTER) || (r_state == ST_EXECUTEI)) &&
                       (Funct[0] || (w_cmd == c_cmd_cmp)) && r_condexl;

   arm_cond_check u_cond (
      .i_cond   (Cond),
      .i_flags  (r_flags),
      .o_condex (w_condex)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_FETCH;
      else       r_state <= w_next;
   end

   // NZCV register and the condition result latched at decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags   <= FLAGS_RST;
         r_condexl <= 1'b0;
      end else begin
         if (r_state == ST_DECODE) r_condexl <= w_condex;
         if (w_flag_upd) begin
            r_flags[c_flag_n] <= ALUFlags[c_flag_n];
            r_flags[c_flag_z] <= ALUFlags[c_flag_z];
            if (!w_alu[1]) begin
               r_flags[c_flag_c] <= ALUFlags[c_flag_c];
               r_flags[c_flag_v] <= ALUFlags[c_flag_v];
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = ST_FETCH;
      case (r_state)
         ST_FETCH:  w_next = ST_DECODE;
         ST_DECODE: begin
            case (Op)
               2'b01:   w_next = ST_MEMADR;
               2'b00:   w_next = Funct[5] ? ST_EXECUTEI : ST_EXECUTER;
               2'b10:   w_next = ST_BRANCH;
               default: w_next = ST_FETCH;
            endcase
         end
         ST_MEMADR:   w_next = Funct[0] ? ST_MEMREAD : ST_MEMWRITE;
         ST_MEMREAD:  w_next = ST_MEMWB;
         ST_EXECUTER: w_next = ST_ALUWB;
         ST_EXECUTEI: w_next = ST_ALUWB;
         default:     w_next = ST_FETCH;
      endcase
   end

   // Moore output decode, write enables gated by the latched condition
   always_comb begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = c_alu_add;
      case (r_state)
         ST_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         ST_DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         ST_MEMADR:  ALUSrcB = 2'b01;
         ST_MEMREAD: AdrSrc  = 1'b1;
         ST_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = r_condexl;
         end
         ST_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = r_condexl;
         end
         ST_EXECUTER: ALUControl = w_alu;
         ST_EXECUTEI: begin
            ALUSrcB    = 2'b01;
            ALUControl = w_alu;
         end
         ST_ALUWB: begin
            RegWrite = w_dp_wr;
            PCWrite  = w_dp_wr & (Rd == 4'b1111);
         end
         ST_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = r_condexl;
         end
         default: ;
      endcase
   end

   // Instruction-class decodes independent of state
   assign ImmSrc    = Op;
   assign RegSrc[0] = (Op == 2'b10);
   assign RegSrc[1] = (Op == 2'b01);

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_mc_controller
// Brief    : Directed bench for arm_mc_controller; each step compares the
//            packed control outputs against hand-computed per-state values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_mc_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] Cond = 4'b1110;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'b000000;
   logic [3:0] Rd = 4'b0000;
   logic [3:0] ALUFlags = 4'b0000;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   int n_vec = 0;
   int n_err = 0;

   logic [16:0] w_ctl;

   arm_mc_controller #(.FLAGS_RST(4'b0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .RegSrc     (RegSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl)
   );

   always #5 clk = ~clk;

   assign w_ctl = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

   // Pack an expected control word in the same order as w_ctl
   function automatic logic [16:0] ctl(input logic pc, input logic mw, input logic rw,
                                       input logic ir, input logic ad,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [1:0] alu);
      return {pc, mw, rw, ir, ad, rs, sa, sb, res, imm, alu};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and sample mid-low-phase
   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] rd, input logic [3:0] af);
      Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
      #1;
   endtask

   // Unconditional CMP used to preload NZCV (4 cycles, ends in FETCH)
   task automatic run_cmp(input logic [3:0] af);
      instr(4'b1110, 2'b00, 6'b110101, 4'b0000, af);
      repeat (4) tick;
   endtask

   initial begin
      // Asynchronous reset before any clock edge
      #2 reset = 1'b1;
      #1;
      check("rst_ctl", w_ctl, ctl(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));
      check("rst_flags", dut.r_flags, 4'b0000);
      check("rst_condexl", dut.r_condexl, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;

      // ADD R1,R2,R3
      instr(4'b1110, 2'b00, 6'b001000, 4'b0001, 4'b0000);
      check("add_fetch",  w_ctl, ctl(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00)); tick;
      check("add_decode", w_ctl, ctl(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00)); tick;
      check("add_exec",   w_ctl, ctl(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00)); tick;
      check("add_aluwb",  w_ctl, ctl(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00)); tick;

      // CMP #imm, ALU reports Z
      instr(4'b1110, 2'b00, 6'b110101, 4'b0000, 4'b0100);
      tick; tick;
      check("cmp_execi", w_ctl, ctl(0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,2'b01)); tick;
      check("cmp_aluwb", w_ctl, ctl(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
      check("cmp_flags", dut.r_flags, 4'b0100); tick;

      // BEQ taken
      instr(4'b0000, 2'b10, 6'b100000, 4'b0000, 4'b0000);
      check("beq_fetch",  w_ctl, ctl(1,0,0,1,0, 2'b01,2'b01,2'b10,2'b10,2'b10,2'b00)); tick;
      check("beq_decode", w_ctl, ctl(0,0,0,0,0, 2'b01,2'b01,2'b10,2'b10,2'b10,2'b00)); tick;
      check("beq_branch", w_ctl, ctl(1,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,2'b00)); tick;

      // ANDS with prior flags 0011: N,Z from ALU, C,V kept
      run_cmp(4'b0011);
      check("pre_and_flags", dut.r_flags, 4'b0011);
      instr(4'b1110, 2'b00, 6'b000001, 4'b0010, 4'b1000);
      tick; tick;
      check("and_exec",  w_ctl, ctl(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b10)); tick;
      check("and_aluwb", w_ctl, ctl(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
      check("and_flags", dut.r_flags, 4'b1011); tick;

      // BNE with Z=1: full path, no PC write
      run_cmp(4'b0100);
      instr(4'b0001, 2'b10, 6'b100000, 4'b0000, 4'b0000);
      tick; tick;
      check("bne_branch",  w_ctl, ctl(0,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,2'b00)); tick;
      check("bne_refetch", w_ctl, ctl(1,0,0,1,0, 2'b01,2'b01,2'b10,2'b10,2'b10,2'b00));

      // STR EQ with Z=0: MemWrite suppressed
      run_cmp(4'b0000);
      instr(4'b0000, 2'b01, 6'b011000, 4'b0011, 4'b0000);
      check("streq_fetch",  w_ctl, ctl(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00)); tick;
      tick;
      check("streq_memadr", w_ctl, ctl(0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00,2'b01,2'b00)); tick;
      check("streq_memwr",  w_ctl, ctl(0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b01,2'b00)); tick;
      check("streq_refetch", w_ctl, ctl(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));

      // CMPEQ with Z=0: flags must not change
      instr(4'b0000, 2'b00, 6'b110101, 4'b0000, 4'b0100);
      tick; tick;
      check("cmpeq_execi", w_ctl, ctl(0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,2'b01)); tick;
      tick;
      check("cmpeq_flags", dut.r_flags, 4'b0000);

      // STR AL: MemWrite asserted
      instr(4'b1110, 2'b01, 6'b011000, 4'b0011, 4'b0000);
      tick; tick; tick;
      check("str_memwr", w_ctl, ctl(0,1,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b01,2'b00)); tick;

      // LDR: 5-cycle path
      instr(4'b1110, 2'b01, 6'b011001, 4'b0100, 4'b0000);
      tick; tick; tick;
      check("ldr_memrd",   w_ctl, ctl(0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b01,2'b00)); tick;
      check("ldr_memwb",   w_ctl, ctl(0,0,1,0,0, 2'b10,2'b00,2'b00,2'b01,2'b01,2'b00)); tick;
      check("ldr_refetch", w_ctl, ctl(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));

      // ORR PC,...: writes PC and register
      instr(4'b1110, 2'b00, 6'b011000, 4'b1111, 4'b0000);
      tick; tick;
      check("orr_exec",  w_ctl, ctl(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b11)); tick;
      check("orr_aluwb", w_ctl, ctl(1,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00)); tick;

      // Undefined Op=11: decode then straight back to fetch
      instr(4'b1110, 2'b11, 6'b000000, 4'b0000, 4'b0000);
      tick;
      check("op3_decode",  w_ctl, ctl(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b11,2'b00)); tick;
      check("op3_refetch", w_ctl, ctl(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b11,2'b00));

      // Reset asserted mid-cycle during MEMWB of an LDR
      run_cmp(4'b1111);
      check("pre_rst_flags", dut.r_flags, 4'b1111);
      instr(4'b1110, 2'b01, 6'b011001, 4'b0001, 4'b0000);
      repeat (4) tick;
      check("rst_memwb", w_ctl, ctl(0,0,1,0,0, 2'b10,2'b00,2'b00,2'b01,2'b01,2'b00));
      #1 reset = 1'b1;
      #1;
      check("rst_async_ctl",   w_ctl, ctl(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));
      check("rst_async_flags", dut.r_flags, 4'b0000);
      check("rst_async_cxl",   dut.r_condexl, 1'b0);
      tick;
      check("rst_hold_ctl", w_ctl, ctl(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));
      reset = 1'b0;
      tick;
      check("rst_after_decode", w_ctl, ctl(0,0,0,0,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
